// File: rtl/deflate_pkg.sv
// rtl/deflate_pkg.sv - DEFLATE fixed-table encodings shared by the coder and the packer
package deflate_pkg;

    typedef enum logic [1:0] {
        KIND_LIT  = 2'b00,
        KIND_LEN  = 2'b01,
        KIND_DIST = 2'b10,
        KIND_RSV  = 2'b11
    } sym_kind_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_EOB,
        ST_PAD
    } pk_state_e;

    localparam int MAX_SYM_BITS = 18;

    // End-of-block is literal/length symbol 256: seven zero bits.
    localparam logic [6:0] EOB_CODE  = 7'b0000000;
    localparam int         EOB_NBITS = 7;

    // Length codes 257..285: smallest length covered by each code and its extra-bit count.
    localparam logic [8:0] LEN_BASE [0:28] = '{
        9'd3,   9'd4,   9'd5,   9'd6,   9'd7,   9'd8,   9'd9,   9'd10,
        9'd11,  9'd13,  9'd15,  9'd17,  9'd19,  9'd23,  9'd27,  9'd31,
        9'd35,  9'd43,  9'd51,  9'd59,  9'd67,  9'd83,  9'd99,  9'd115,
        9'd131, 9'd163, 9'd195, 9'd227, 9'd258
    };
    localparam logic [2:0] LEN_EXTRA [0:28] = '{
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4,
        3'd5, 3'd5, 3'd5, 3'd5, 3'd0
    };

    // Distance codes 0..29, bases stored as distance-1 to match the sym_data encoding.
    localparam logic [14:0] DIST_BASE_M1 [0:29] = '{
        15'd0,     15'd1,     15'd2,     15'd3,     15'd4,     15'd6,
        15'd8,     15'd12,    15'd16,    15'd24,    15'd32,    15'd48,
        15'd64,    15'd96,    15'd128,   15'd192,   15'd256,   15'd384,
        15'd512,   15'd768,   15'd1024,  15'd1536,  15'd2048,  15'd3072,
        15'd4096,  15'd6144,  15'd8192,  15'd12288, 15'd16384, 15'd24576
    };
    localparam logic [3:0] DIST_EXTRA [0:29] = '{
        4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd2,  4'd2,
        4'd3,  4'd3,  4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,
        4'd7,  4'd7,  4'd8,  4'd8,  4'd9,  4'd9,  4'd10, 4'd10,
        4'd11, 4'd11, 4'd12, 4'd12, 4'd13, 4'd13
    };

    // Reverse the low n bits of a Huffman code so its MSB becomes stream bit 0.
    function automatic logic [8:0] rev_code(input logic [8:0] c, input logic [3:0] n);
        logic [8:0] r;
        for (int i = 0; i < 9; i++) begin
            r[i] = c[8-i];
        end
        return r >> (4'd9 - n);
    endfunction

endpackage

// File: rtl/deflate_fixed_coder.sv
// rtl/deflate_fixed_coder.sv - combinational DEFLATE fixed-table symbol coder
module deflate_fixed_coder
    import deflate_pkg::*;
(
    input  logic [1:0]  sym_kind,
    input  logic [14:0] sym_data,
    output logic [17:0] bits,
    output logic [4:0]  nbits,
    output logic        err
);

    logic [8:0]  code;
    logic [3:0]  code_n;
    logic [12:0] extra;
    logic [3:0]  extra_n;
    logic [4:0]  idx;
    logic [7:0]  lit;
    logic [8:0]  len;

    assign lit = sym_data[7:0];
    assign len = sym_data[8:0];

    always_comb begin
        code    = '0;
        code_n  = '0;
        extra   = '0;
        extra_n = '0;
        idx     = '0;
        err     = 1'b0;
        case (sym_kind)
            KIND_LIT: begin
                if (lit < 8'd144) begin
                    code   = 9'h030 + 9'(lit);
                    code_n = 4'd8;
                end else begin
                    code   = 9'h190 + 9'(lit - 8'd144);
                    code_n = 4'd9;
                end
            end
            KIND_LEN: begin
                if (len < 9'd3 || len > 9'd258) begin
                    err = 1'b1;
                end else begin
                    for (int i = 0; i < 29; i++) begin
                        if (len >= LEN_BASE[i]) idx = 5'(i);
                    end
                    // Codes 257..279 are 7-bit (value code-256), 280..285 are 8-bit from 0xC0.
                    if (idx <= 5'd22) begin
                        code   = 9'(idx) + 9'd1;
                        code_n = 4'd7;
                    end else begin
                        code   = 9'h0C0 + 9'(idx) - 9'd23;
                        code_n = 4'd8;
                    end
                    extra   = 13'(len - LEN_BASE[idx]);
                    extra_n = 4'(LEN_EXTRA[idx]);
                end
            end
            KIND_DIST: begin
                for (int i = 0; i < 30; i++) begin
                    if (sym_data >= DIST_BASE_M1[i]) idx = 5'(i);
                end
                code    = 9'(idx);
                code_n  = 4'd5;
                extra   = 13'(sym_data - DIST_BASE_M1[idx]);
                extra_n = DIST_EXTRA[idx];
            end
            default: err = 1'b1;
        endcase
    end

    // Extra bits sit directly above the reversed code, LSB first.
    assign bits  = err ? '0 : (18'(rev_code(code, code_n)) | (18'(extra) << code_n));
    assign nbits = err ? '0 : (5'(code_n) + 5'(extra_n));

endmodule

// File: rtl/deflate_huffman_packer.sv
// rtl/deflate_huffman_packer.sv - DEFLATE fixed-Huffman symbol packer; DEFLATE_EOB_EN adds end-of-block on flush
module deflate_huffman_packer
    import deflate_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym_kind,
    input  logic [14:0]      sym_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] bits_total,
    output logic             err_kind
);

`ifdef DEFLATE_EOB_EN
    localparam int EOB_ROOM = EOB_NBITS;
`else
    localparam int EOB_ROOM = 0;
`endif
    // Headroom lets EOB land right after a symbol accepted in the same cycle as flush.
    localparam int ACC_W = OUT_W + MAX_SYM_BITS + EOB_ROOM;
    localparam int BC_W  = $clog2(ACC_W + 1);
    localparam logic [BC_W-1:0] WORD = BC_W'(OUT_W);

    pk_state_e        state, state_next;
    logic [ACC_W-1:0] acc;
    logic [BC_W-1:0]  bit_count;
    logic [17:0]      c_bits;
    logic [4:0]       c_nbits;
    logic             c_err;
    logic             word_full;
    logic             append_eob;
    logic             accept;
    logic             emit;

    deflate_fixed_coder u_coder (
        .sym_kind (sym_kind),
        .sym_data (sym_data),
        .bits     (c_bits),
        .nbits    (c_nbits),
        .err      (c_err)
    );

    assign word_full = (bit_count >= WORD);
    assign accept    = sym_valid & sym_ready;
    assign emit      = out_valid & out_ready;
    assign out_data  = acc[OUT_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        sym_ready  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        append_eob = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    sym_ready = !word_full;
                    out_valid = word_full;
                    if (flush && !word_full) begin
`ifdef DEFLATE_EOB_EN
                        state_next = ST_EOB;
`else
                        state_next = ST_PAD;
`endif
                    end
                end
                ST_EOB: begin
                    append_eob = 1'b1;
                    state_next = ST_PAD;
                end
                ST_PAD: begin
                    // The word holding the tail (up to a full word) is the last one.
                    out_valid = (bit_count != '0);
                    out_last  = out_valid && (bit_count <= WORD);
                    if (bit_count == '0 || (out_last && out_ready)) state_next = ST_RUN;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= '0;
            bit_count  <= '0;
            bits_total <= '0;
            err_kind   <= 1'b0;
        end else if (accept) begin
            acc        <= acc | (ACC_W'(c_bits) << bit_count);
            bit_count  <= bit_count + BC_W'(c_nbits);
            bits_total <= bits_total + CNT_W'(c_nbits);
            if (c_err) err_kind <= 1'b1;
        end else if (append_eob) begin
            acc        <= acc | (ACC_W'(EOB_CODE) << bit_count);
            bit_count  <= bit_count + BC_W'(EOB_NBITS);
            bits_total <= bits_total + CNT_W'(EOB_NBITS);
        end else if (emit) begin
            acc       <= acc >> OUT_W;
            bit_count <= word_full ? (bit_count - WORD) : '0;
        end
    end

endmodule

// File: tb/tb_deflate_huffman_packer.sv
// tb/tb_deflate_huffman_packer.sv - randomized self-checking bench for deflate_huffman_packer
module tb_deflate_huffman_packer;

`ifdef DEFLATE_EOB_EN
    localparam int EOB_BITS = 7;
`else
    localparam int EOB_BITS = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [1:0]  sym_kind = 2'b00;
    logic [14:0] sym_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic [31:0] bits_total;
    logic        err_kind;

    bit          rand_ready = 1'b0;
    bit          hold_ready = 1'b1;

    bit          mq[$];
    logic [31:0] exp_words[$];
    bit          exp_lasts[$];
    logic [31:0] dut_words[$];
    bit          dut_lasts[$];
    logic [31:0] exp_total;
    bit          exp_err;
    int          timeouts = 0;
    int          passed = 0;
    int          total = 0;

    deflate_huffman_packer #(.OUT_W(32), .CNT_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_kind   (sym_kind),
        .sym_data   (sym_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .bits_total (bits_total),
        .err_kind   (err_kind)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : hold_ready;
    end

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            dut_words.push_back(out_data);
            dut_lasts.push_back(out_last);
        end
    end

    // ---------------- reference model: a plain bit queue ----------------
    function automatic void push_bits(input int val, input int n, input bit msb_first);
        for (int i = 0; i < n; i++) mq.push_back(bit'((val >> (msb_first ? n - 1 - i : i)) & 1));
        exp_total += 32'(n);
    endfunction

    function automatic void take_word(input bit last);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) if (mq.size() > 0) w[i] = mq.pop_front();
        exp_words.push_back(w);
        exp_lasts.push_back(last);
    endfunction

    function automatic void model_drain_run();
        while (mq.size() >= 32) take_word(1'b0);
    endfunction

    function automatic void model_push(input logic [1:0] k, input logic [14:0] d);
        int v, base, e, c, ev;
        case (k)
            2'b00: begin
                v = int'(d[7:0]);
                if (v < 144) push_bits(48 + v, 8, 1'b1);
                else         push_bits(400 + v - 144, 9, 1'b1);
            end
            2'b01: begin
                v = int'(d[8:0]);
                if (v < 3 || v > 258) exp_err = 1'b1;
                else begin
                    c = 285; e = 0; ev = 0;
                    if (v != 258) begin
                        base = 3;
                        for (int i = 0; i < 28; i++) begin
                            e = (i < 8) ? 0 : (i - 4) / 4;
                            if (v < base + (1 << e)) begin c = 257 + i; ev = v - base; break; end
                            base += (1 << e);
                        end
                    end
                    if (c < 280) push_bits(c - 256, 7, 1'b1);
                    else         push_bits(192 + c - 280, 8, 1'b1);
                    push_bits(ev, e, 1'b0);
                end
            end
            2'b10: begin
                v = int'(d) + 1;
                base = 1; c = 0; e = 0; ev = 0;
                for (int i = 0; i < 30; i++) begin
                    e = (i < 4) ? 0 : (i - 2) / 2;
                    if (v < base + (1 << e)) begin c = i; ev = v - base; break; end
                    base += (1 << e);
                end
                push_bits(c, 5, 1'b1);
                push_bits(ev, e, 1'b0);
            end
            default: exp_err = 1'b1;
        endcase
    endfunction

    function automatic void model_finish();
        push_bits(0, EOB_BITS, 1'b1);
        while (mq.size() > 32) take_word(1'b0);
        if (mq.size() > 0) take_word(1'b1);
    endfunction

    function automatic void model_clear();
        mq.delete(); exp_words.delete(); exp_lasts.delete();
        dut_words.delete(); dut_lasts.delete();
        exp_total = '0;
        exp_err = 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; sym_valid = 1'b0; flush = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic xfer(input bit v, input logic [1:0] k, input logic [14:0] d, input bit fl);
        int n = 0;
        @(posedge clock); #1;
        sym_valid = v; sym_kind = k; sym_data = d; flush = fl;
        @(negedge clock);
        while (!sym_ready && n < 300) begin @(negedge clock); n++; end
        if (!sym_ready) timeouts++;
        else begin
            model_drain_run();
            if (v)  model_push(k, d);
            if (fl) model_finish();
        end
        @(posedge clock); #1;
        sym_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (dut_words.size() < exp_words.size() && n < 3000) begin @(negedge clock); n++; end
        ok = (dut_words.size() >= exp_words.size());
        repeat (4) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        total++; if (sym_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_hs: sym_ready=%b out_valid=%b want 0/0", sym_ready, out_valid); else passed++;
        @(posedge clock); #1 reset = 1'b0;
        model_clear();
        @(negedge clock);
        total++; if ({bits_total, out_data, err_kind, out_last, out_valid} !== '0) $display("FAIL reset_state: bits_total=%0d out_data=%h err=%b last=%b valid=%b want zeros", bits_total, out_data, err_kind, out_last, out_valid); else passed++;
        total++; if (sym_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", sym_ready); else passed++;
    endtask

    task automatic test_literals();
        bit ok;
        do_reset();
        repeat (4) xfer(1'b1, 2'b00, 15'h41, 1'b0);
        model_drain_run(); wait_drain(ok);
        total++; if (!ok || dut_words.size() != 1 || dut_words[0] !== 32'h8E8E8E8E || dut_lasts[0] !== 1'b0) $display("FAIL lit_word: got %0d words first=%h want 1 word 8e8e8e8e last=0", dut_words.size(), (dut_words.size() > 0) ? dut_words[0] : 32'h0); else passed++;
        total++; if (bits_total !== 32'd32) $display("FAIL lit_total: got %0d want 32", bits_total); else passed++;
    endtask

    task automatic test_len_dist_flush();
        bit ok;
        do_reset();
        xfer(1'b1, 2'b01, 15'd3, 1'b0);
        xfer(1'b1, 2'b10, 15'd0, 1'b0);
        xfer(1'b0, 2'b00, 15'd0, 1'b1);
        wait_drain(ok);
        total++; if (!ok || dut_words.size() != 1 || dut_words[0] !== 32'h40 || dut_lasts[0] !== 1'b1) $display("FAIL ld_word: got %0d words first=%h want 1 word 00000040 last=1", dut_words.size(), (dut_words.size() > 0) ? dut_words[0] : 32'h0); else passed++;
        total++; if (bits_total !== 32'(12 + EOB_BITS)) $display("FAIL ld_total: got %0d want %0d", bits_total, 12 + EOB_BITS); else passed++;
        total++; if (sym_ready !== 1'b1) $display("FAIL ld_back_to_run: sym_ready=%b want 1", sym_ready); else passed++;
    endtask

    task automatic test_max_symbol();
        bit ok;
        do_reset();
        xfer(1'b1, 2'b01, 15'd258, 1'b0);
        xfer(1'b1, 2'b10, 15'd32767, 1'b0);
        repeat (5) @(negedge clock);
        total++; if (bits_total !== 32'd26 || dut_words.size() != 0) $display("FAIL max_hold: bits_total=%0d words=%0d want 26/0", bits_total, dut_words.size()); else passed++;
        xfer(1'b0, 2'b00, 15'd0, 1'b1);
        wait_drain(ok);
        total++; if (!ok || dut_words.size() != 1 || dut_words[0] !== 32'h03FFF7A3 || dut_lasts[0] !== 1'b1) $display("FAIL max_word: got %0d words first=%h want 1 word 03fff7a3 last=1", dut_words.size(), (dut_words.size() > 0) ? dut_words[0] : 32'h0); else passed++;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] w, held;
        bit l, el;
        hold_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) xfer(1'b1, 2'b00, 15'($urandom_range(0, 143)), 1'b0);
        @(negedge clock);
        held = out_data;
        total++; if (sym_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL bp_stall: sym_ready=%b out_valid=%b want 0/1", sym_ready, out_valid); else passed++;
        repeat (5) @(negedge clock);
        total++; if (out_data !== held || out_valid !== 1'b1 || sym_ready !== 1'b0) $display("FAIL bp_stable: out_data=%h valid=%b ready=%b want %h/1/0", out_data, out_valid, sym_ready, held); else passed++;
        hold_ready = 1'b1;
        model_drain_run(); wait_drain(ok);
        total++; if (!ok || dut_words.size() != exp_words.size()) $display("FAIL bp_count: got %0d want %0d", dut_words.size(), exp_words.size()); else passed++;
        while (dut_words.size() > 0 && exp_words.size() > 0) begin
            w = dut_words.pop_front(); l = dut_lasts.pop_front();
            held = exp_words.pop_front(); el = exp_lasts.pop_front();
            total++; if (w !== held || l !== el) $display("FAIL bp_word: got %h/%b want %h/%b", w, l, held, el); else passed++;
        end
        total++; if (sym_ready !== 1'b1) $display("FAIL bp_release: sym_ready=%b want 1", sym_ready); else passed++;
    endtask

    task automatic test_errors();
        int t0;
        do_reset();
        t0 = timeouts;
        xfer(1'b1, 2'b11, 15'd5, 1'b0);
        @(negedge clock);
        total++; if (err_kind !== 1'b1 || bits_total !== 32'd0) $display("FAIL err_rsv: err=%b bits_total=%0d want 1/0", err_kind, bits_total); else passed++;
        do_reset();
        xfer(1'b1, 2'b01, 15'd2, 1'b0);
        xfer(1'b1, 2'b01, 15'd259, 1'b0);
        xfer(1'b1, 2'b00, 15'd0, 1'b0);
        @(negedge clock);
        total++; if (err_kind !== 1'b1 || bits_total !== 32'd8) $display("FAIL err_len: err=%b bits_total=%0d want 1/8", err_kind, bits_total); else passed++;
        total++; if (timeouts !== t0) $display("FAIL err_handshake: timeouts=%0d want %0d", timeouts, t0); else passed++;
    endtask

    task automatic test_random();
        bit ok, fl, l, el;
        int r;
        logic [1:0] k;
        logic [14:0] d;
        logic [31:0] w, ew;
        int t0;
        do_reset();
        t0 = timeouts;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      begin k = 2'b11; d = 15'($urandom_range(0, 32767)); end
            else if (r == 1) begin k = 2'b01; d = ($urandom_range(0, 1) != 0) ? 15'($urandom_range(0, 2)) : 15'($urandom_range(259, 511)); end
            else if (r < 9)  begin k = 2'b00; d = 15'($urandom_range(0, 255)); end
            else if (r < 14) begin k = 2'b01; d = 15'($urandom_range(3, 258)); end
            else             begin k = 2'b10; d = 15'($urandom_range(0, 32767)); end
            fl = ($urandom_range(0, 24) == 0);
            xfer(1'b1, k, d, fl);
            if ($urandom_range(0, 29) == 0) xfer(1'b0, 2'b00, 15'd0, 1'b1);
        end
        xfer(1'b0, 2'b00, 15'd0, 1'b1);
        wait_drain(ok);
        total++; if (!ok || dut_words.size() != exp_words.size()) $display("FAIL rnd_count: got %0d want %0d", dut_words.size(), exp_words.size()); else passed++;
        while (dut_words.size() > 0 && exp_words.size() > 0) begin
            w = dut_words.pop_front(); l = dut_lasts.pop_front();
            ew = exp_words.pop_front(); el = exp_lasts.pop_front();
            total++; if (w !== ew || l !== el) $display("FAIL rnd_word: got %h/%b want %h/%b", w, l, ew, el); else passed++;
        end
        total++; if (bits_total !== exp_total) $display("FAIL rnd_total: got %0d want %0d", bits_total, exp_total); else passed++;
        total++; if (err_kind !== exp_err) $display("FAIL rnd_err: got %b want %b", err_kind, exp_err); else passed++;
        total++; if (timeouts !== t0) $display("FAIL rnd_timeout: timeouts=%0d want %0d", timeouts, t0); else passed++;
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] w, ew;
        bit l, el;
        do_reset();
        xfer(1'b1, 2'b00, 15'd0, 1'b0);
        xfer(1'b1, 2'b01, 15'd3, 1'b0);
        xfer(1'b1, 2'b10, 15'd0, 1'b0);
        @(negedge clock);
        total++; if (bits_total !== 32'd20) $display("FAIL mid_prefill: bits_total=%0d want 20", bits_total); else passed++;
        do_reset();
        @(negedge clock);
        total++; if (out_valid !== 1'b0 || bits_total !== 32'd0 || out_data !== 32'd0) $display("FAIL mid_reset: valid=%b bits_total=%0d out_data=%h want 0/0/0", out_valid, bits_total, out_data); else passed++;
        xfer(1'b0, 2'b00, 15'd0, 1'b1);
        wait_drain(ok);
        total++; if (!ok || dut_words.size() != exp_words.size()) $display("FAIL mid_count: got %0d want %0d", dut_words.size(), exp_words.size()); else passed++;
        while (dut_words.size() > 0 && exp_words.size() > 0) begin
            w = dut_words.pop_front(); l = dut_lasts.pop_front();
            ew = exp_words.pop_front(); el = exp_lasts.pop_front();
            total++; if (w !== ew || l !== el) $display("FAIL mid_word: got %h/%b want %h/%b", w, l, ew, el); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_literals();
        test_len_dist_flush();
        test_max_symbol();
        test_backpressure();
        test_errors();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
